// File: rtl/reflet_fifo_mmio_pkg.sv
// Register map and bit positions shared by the reflet FIFO mailbox.
package reflet_fifo_mmio_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_addr_e;

  localparam int unsigned STAT_EMPTY     = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVF       = 2;
  localparam int unsigned STAT_COUNT_LSB = 3;

  localparam int unsigned CTRL_INT_EN  = 0;
  localparam int unsigned CTRL_CLR_OVF = 1;
  localparam int unsigned CTRL_FLUSH   = 2;

endpackage

// File: rtl/reflet_fifo_core.sv
// Synchronous FIFO with push/pop, occupancy count and flush.
// A push into a full FIFO is still accepted when a pop happens on the same edge.
module reflet_fifo_core #(
  parameter int unsigned width      = 16,
  parameter int unsigned depth_log2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [width-1:0]      wdata,
  output logic [width-1:0]      head_c,
  output logic [depth_log2:0]   count,
  output logic                  full_c,
  output logic                  empty_c,
  output logic                  drop_c
);

  localparam int unsigned depth = 1 << depth_log2;
  localparam int unsigned pw    = depth_log2;
  localparam int unsigned cw    = depth_log2 + 1;

  logic [width-1:0] mem [depth];
  logic [pw-1:0]    wr_ptr;
  logic [pw-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty_c = (count == '0);
  assign full_c  = (count == cw'(depth));
  assign do_pop  = pop && !empty_c && !flush;
  assign do_push = push && !flush && (!full_c || do_pop);
  assign drop_c  = push && !flush && full_c && !do_pop;
  assign head_c  = mem[rd_ptr];

  // Storage needs no reset; contents are meaningless while count is 0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + pw'(1);
      if (do_pop)  rd_ptr <= rd_ptr + pw'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + cw'(1);
        2'b01:   count <= count - cw'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reflet_fifo_mmio.sv
// Memory-mapped transmit mailbox on the reflet CPU bus with a stream drain side.
// Optional macro REFLET_FIFO_MMIO_PEEK_EN: DATA reads return the head word without popping.
module reflet_fifo_mmio
  import reflet_fifo_mmio_pkg::*;
#(
  parameter int unsigned wordsize   = 16,
  parameter int unsigned depth_log2 = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic [wordsize-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                irq
);

  localparam int unsigned cw = depth_log2 + 1;

  logic [cw-1:0]       count;
  logic                full_c;
  logic                empty_c;
  logic                drop_c;
  logic [wordsize-1:0] head_c;
  logic                bus_wr;
  logic                bus_rd;
  logic                push;
  logic                pop;
  logic                ctrl_wr;
  logic                flush;
  logic                overflow;
  logic                int_en;
  logic [wordsize-1:0] rd_word;
  reg_addr_e           reg_sel;

  assign reg_sel   = reg_addr_e'(addr);
  assign bus_wr    = enable && write_en;
  assign bus_rd    = enable && !write_en;
  assign push      = bus_wr && (reg_sel == REG_DATA);
  assign ctrl_wr   = bus_wr && (reg_sel == REG_CTRL);
  assign flush     = ctrl_wr && data_in[CTRL_FLUSH];
  assign out_valid = !empty_c;
  assign pop       = out_valid && out_ready;
  assign out_data  = head_c;

  reflet_fifo_core #(
    .width      (wordsize),
    .depth_log2 (depth_log2)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   (data_in),
    .head_c  (head_c),
    .count   (count),
    .full_c  (full_c),
    .empty_c (empty_c),
    .drop_c  (drop_c)
  );

  // Read mux reflects state before the access edge.
  always_comb begin
    rd_word = '0;
    case (reg_sel)
      REG_DATA: begin
`ifdef REFLET_FIFO_MMIO_PEEK_EN
        if (!empty_c) rd_word = head_c;
`endif
      end
      REG_STATUS: begin
        rd_word[STAT_EMPTY]              = empty_c;
        rd_word[STAT_FULL]               = full_c;
        rd_word[STAT_OVF]                = overflow;
        rd_word[STAT_COUNT_LSB +: cw]    = count;
      end
      REG_CTRL: rd_word[CTRL_INT_EN] = int_en;
      default:  rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      int_en   <= 1'b0;
      irq      <= 1'b0;
      data_out <= '0;
    end else begin
      if (ctrl_wr) begin
        int_en <= data_in[CTRL_INT_EN];
        if (data_in[CTRL_CLR_OVF]) overflow <= 1'b0;
      end else if (drop_c) begin
        overflow <= 1'b1;
      end
      irq      <= int_en && empty_c;
      data_out <= bus_rd ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_reflet_fifo_mmio.sv
// Scoreboard bench for reflet_fifo_mmio: per-cycle model of stream, read data and irq.
module tb_reflet_fifo_mmio;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 8;

  logic         clk      = 1'b0;
  logic         reset    = 1'b1;
  logic         enable   = 1'b0;
  logic [1:0]   addr     = 2'd0;
  logic [W-1:0] data_in  = '0;
  logic         write_en = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] data_out;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         irq;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb_q[$];
  logic [W-1:0] rd_q[$];
  logic         m_ovf = 1'b0;
  logic         m_int_en = 1'b0;
  logic         m_irq = 1'b0;

  always #5 clk = ~clk;

  reflet_fifo_mmio #(.wordsize(16), .depth_log2(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .addr      (addr),
    .data_in   (data_in),
    .write_en  (write_en),
    .data_out  (data_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_read(input logic [1:0] a);
    logic [W-1:0] v;
    int n;
    v = '0;
    n = sb_q.size();
    case (a)
      2'd0: begin
`ifdef REFLET_FIFO_MMIO_PEEK_EN
        if (n != 0) v = sb_q[0];
`endif
      end
      2'd1: begin
        v[0]   = (n == 0);
        v[1]   = (n == DEPTH);
        v[2]   = m_ovf;
        v[6:3] = 4'(n);
      end
      2'd2: v[0] = m_int_en;
      default: v = '0;
    endcase
    return v;
  endfunction

  // One clock: check stream head, predict the edge, then compare registered outputs.
  task automatic step();
    int           pre_n;
    logic         pop;
    logic         irq_next;
    logic         wr;
    logic [W-1:0] d;
    logic [1:0]   a;
    pre_n = sb_q.size();
    check("out_valid", 32'(out_valid), 32'(pre_n != 0));
    if (pre_n != 0) check("out_data", 32'(out_data), 32'(sb_q[0]));
    rd_q.push_back((enable && !write_en) ? model_read(addr) : '0);
    irq_next = m_int_en && (pre_n == 0);
    pop = (pre_n != 0) && out_ready;
    wr = enable && write_en;
    d = data_in;
    a = addr;
    @(posedge clk);
    #1;
    if (wr && a == 2'd2 && d[2]) begin
      sb_q.delete();
    end else begin
      if (pop) void'(sb_q.pop_front());
      if (wr && a == 2'd0) begin
        if (pre_n < DEPTH || pop) sb_q.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    if (wr && a == 2'd2) begin
      m_int_en = d[0];
      if (d[1]) m_ovf = 1'b0;
    end
    m_irq = irq_next;
    check("data_out", 32'(data_out), 32'(rd_q.pop_front()));
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic idle(input int n);
    enable = 1'b0;
    write_en = 1'b0;
    repeat (n) step();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [W-1:0] d);
    enable = 1'b1; write_en = 1'b1; addr = a; data_in = d;
    step();
    enable = 1'b0; write_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [W-1:0] v);
    enable = 1'b1; write_en = 1'b0; addr = a;
    step();
    v = data_out;
    enable = 1'b0;
  endtask

  task automatic model_reset();
    sb_q.delete();
    rd_q.delete();
    m_ovf = 1'b0;
    m_int_en = 1'b0;
    m_irq = 1'b0;
  endtask

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] peek_exp;

    // Power-on reset
    #2 reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Test 1: reset STATUS
    bus_rd(2'd1, v);
    check("t1_status", 32'(v), 32'h0001);
    bus_rd(2'd2, v);
    check("t1_ctrl", 32'(v), 32'h0000);

    // Test 2: two pushes then drain
    bus_wr(2'd0, 16'h1234);
    bus_wr(2'd0, 16'hABCD);
    bus_rd(2'd1, v);
    check("t2_status", 32'(v), 32'h0010);
    check("t2_head", 32'(out_data), 32'h1234);
    out_ready = 1'b1;
    idle(1);
    check("t2_second", 32'(out_data), 32'hABCD);
    idle(1);
    check("t2_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Test 3: overflow then clear
    for (int i = 0; i < 8; i++) bus_wr(2'd0, 16'h0100 + 16'(i));
    bus_wr(2'd0, 16'hDEAD);
    bus_rd(2'd1, v);
    check("t3_status_ovf", 32'(v), 32'h0046);
    bus_wr(2'd2, 16'h0002);
    bus_rd(2'd1, v);
    check("t3_status_clr", 32'(v), 32'h0042);

    // Test 4: push into full FIFO with simultaneous pop
    out_ready = 1'b1;
    bus_wr(2'd0, 16'hBEEF);
    out_ready = 1'b0;
    bus_rd(2'd1, v);
    check("t4_status", 32'(v), 32'h0042);
    out_ready = 1'b1;
    idle(7);
    check("t4_last", 32'(out_data), 32'hBEEF);
    idle(1);
    check("t4_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Reserved offset
    bus_wr(2'd3, 16'hFFFF);
    bus_rd(2'd3, v);
    check("rsvd_read", 32'(v), 32'h0000);

    // Test 5: drain interrupt and asynchronous reset
    bus_wr(2'd2, 16'h0001);
    idle(1);
    check("t5_irq_idle", 32'(irq), 32'd1);
    bus_wr(2'd0, 16'h5555);
    out_ready = 1'b1;
    idle(1);
    check("t5_irq_pop_edge", 32'(irq), 32'd0);
    out_ready = 1'b0;
    idle(1);
    check("t5_irq_after_pop", 32'(irq), 32'd1);
    bus_wr(2'd0, 16'h6666);
    check("t5_pre_rst_valid", 32'(out_valid), 32'd1);
    check("t5_pre_rst_irq", 32'(irq), 32'd1);
    idle(1);
    check("t5_irq_after_push", 32'(irq), 32'd0);
    bus_wr(2'd0, 16'h7777);
    #2 reset = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid), 32'd0);
    check("t5_rst_irq", 32'(irq), 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    bus_rd(2'd1, v);
    check("t5_post_rst_status", 32'(v), 32'h0001);

    // Test 6: DATA read behaviour
`ifdef REFLET_FIFO_MMIO_PEEK_EN
    peek_exp = 16'h00FF;
`else
    peek_exp = 16'h0000;
`endif
    bus_wr(2'd0, 16'h00FF);
    bus_rd(2'd0, v);
    check("t6_peek1", 32'(v), 32'(peek_exp));
    bus_rd(2'd0, v);
    check("t6_peek2", 32'(v), 32'(peek_exp));
    bus_rd(2'd1, v);
    check("t6_status", 32'(v), 32'h0008);

    // Flush clears queue
    bus_wr(2'd2, 16'h0004);
    bus_rd(2'd1, v);
    check("flush_status", 32'(v), 32'h0001);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reflet_fifo_mmio.md
Name: reflet_fifo_mmio

Overview:
Memory-mapped transmit mailbox that acts as a responder on the reflet CPU data bus, the same bus the CPU uses to drive ROM and RAM.
- The CPU pushes words into an internal FIFO through a DATA register.
- An external consumer drains the FIFO over a valid/ready stream.
- STATUS and CTRL registers expose the fill state, a sticky overflow flag and an interrupt that fires when the FIFO drains, intended for one ext_int line.
- data_out is zero whenever the block is not selected, so it can be ORed onto the CPU data_in bus.

Parameters:
wordsize, 16, width of bus data and FIFO entries.
depth_log2, 3, FIFO depth is 2**depth_log2 entries; requires wordsize >= depth_log2+4.

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset; all state cleared while low.
enable  input  1  chip select, decoded from the CPU address upstream.
addr  input  2  register offset: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved.
data_in  input  wordsize  write data from CPU data_out.
write_en  input  1  write strobe, qualified by enable.
data_out  output  wordsize  registered read data, zero when not selected.
out_data  output  wordsize  FIFO head word.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts head this cycle.
irq  output  1  level interrupt.

Behaviour:
- Reset values while reset is low:
  - read/write pointers, count, overflow and int_en cleared.
  - data_out = 0, out_valid = 0, irq = 0.
  - FIFO storage contents are don't-care.
  - A reset mid-transfer discards all queued words immediately, with no clock edge needed.
- Bus access: each rising edge with enable=1 is one access.
  - write_en=1 writes, write_en=0 reads.
  - The CPU guarantees one-cycle write strobes, so each qualifying edge is one write.
- Read latency is 1 cycle:
  - data_out is registered from the addr sampled at the previous edge.
  - data_out = 0 if enable was low at that edge, or if the access was a write.
- DATA write (addr 0): push data_in.
  - Accepted iff count < depth, or a pop occurs on the same edge.
  - If neither holds, the word is dropped and overflow is set (sticky).
- DATA read: returns 0 (see Optional Feature).
- STATUS read (addr 1):
  - bit0 empty, bit1 full, bit2 overflow.
  - bits[3+depth_log2:3] count (depth_log2+1 bits).
  - Upper bits 0.
  - STATUS writes are ignored.
- CTRL write (addr 2):
  - bit0 sets int_en.
  - bit1=1 clears overflow.
  - bit2=1 flushes the FIFO (pointers and count to 0).
  - A push to DATA cannot coincide with a CTRL write, since there is a single address per cycle.
- CTRL read: bit0 int_en, other bits 0.
- Reserved offset 3: reads 0, writes ignored.
- Stream side:
  - out_valid = (count != 0); out_data = storage[rd_ptr], combinational from registered state.
  - Pop on edge where out_valid && out_ready; rd_ptr advances mod depth.
- Simultaneous push and pop:
  - count unchanged, both pointers advance.
  - When full, the push is accepted because of the pop.
  - When empty, no pop occurs (out_valid=0) and the push proceeds; the word appears on out_data the next cycle.
- Pointers wrap naturally at depth; count saturates exactly at depth, never exceeding it.
- irq = int_en && (count == 0), registered. It asserts one cycle after the last word pops and stays asserted until a push or until int_en is cleared.

Optional Feature:
REFLET_FIFO_MMIO_PEEK_EN
- Defined: a DATA read returns the current head word (storage[rd_ptr]) without popping, or 0 if empty.
- Undefined: DATA reads return 0 and no read path from storage to data_out exists.

Decomposition:
- Shared package/include holds the register offsets (DATA=0, STATUS=1, CTRL=2), the STATUS bit positions (EMPTY=0, FULL=1, OVF=2, COUNT_LSB=3) and the CTRL bit positions (INT_EN=0, CLR_OVF=1, FLUSH=2).
- One natural sub-module: reflet_fifo_core, a synchronous FIFO with push/pop, count, full/empty and flush.
- The top level adds bus decode, registers and irq.

Test Plan:
1. Reset low then high, read STATUS -> data_out=0x0001 one cycle after the access; out_valid=0, irq=0.
2. Write 0x1234, 0xABCD to DATA with out_ready=0, read STATUS -> count=2 (0x0010); out_data=0x1234; raise out_ready for 2 cycles -> 0x1234 then 0xABCD, then out_valid=0.
3. Fill 8 words with out_ready=0, write a 9th (0xDEAD) -> dropped; STATUS=0x0046 (count 8, full, overflow); write CTRL=0x2 -> overflow cleared, STATUS=0x0042.
4. FIFO full with out_ready=1 and DATA write on the same edge -> write accepted, count stays 8, the last pushed word emerges 8 pops later.
5. Write CTRL=0x1, push one word, pop it -> irq=1 one cycle after the pop; push again -> irq=0; pull reset low mid-stream -> out_valid and irq drop immediately, with no clock edge needed.
6. With REFLET_FIFO_MMIO_PEEK_EN: push 0x00FF, read DATA twice -> 0x00FF both times, count still 1; without the macro -> reads 0x0000.
